vga_scanout: RTL and testbench

//   Pixel scan-out stage directly downstream of the PPU. Accepts PPU bytes over the
//   stb/ack handshake into a small FIFO and generates 640x480@60 VGA timing
//   (800x525 total). Pops one byte per active pixel and drives 2-bit R/G/B plus

---
 rtl/vga_scanout.sv | 137 +++++++++++++
 tb/tb_vga_scanout.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: PPU byte FIFO feeding a 640x480@60 VGA raster (800x525 total), 2-bit RGB.
// Latency: registered outputs, one cycle after the counters; first word one cycle after push.
// Backpressure: push only when stb_i && !ack_i && !full, so ack_i pulses at most every 2nd cycle.
// Ports: clk/rst (async active-low); data_i/stb_i/ack_i PPU input handshake; sync_o frame-start
//   pulse; vga_r/g/b/hs/vs raster outputs; clr_i clears underflow/uf_count; fifo_level occupancy.
module vga_scanout #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data_i,
  input  logic               stb_i,
  output logic               ack_i,
  output logic               sync_o,
  output logic [1:0]         vga_r,
  output logic [1:0]         vga_g,
  output logic [1:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  input  logic               clr_i,
  output logic               underflow,
  output logic [7:0]         uf_count,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [HW-1:0] sx;
  logic [VW-1:0] sy;

  // Only the colour bits are stored; the two low PPU bits carry nothing.
  logic [5:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_cnt;
  logic [FIFO_AW:0] rd_cnt;
  logic             unused_lsbs;

  logic active;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [5:0] head;

  assign unused_lsbs = ^data_i[1:0];

  // Occupancy from free-running counters one bit wider than the pointers,
  // so full and empty stay distinguishable.
  assign fifo_level = wr_cnt - rd_cnt;
  assign full       = (fifo_level == DEPTH_L);
  assign empty      = (wr_cnt == rd_cnt);
  assign head       = mem[rd_cnt[FIFO_AW-1:0]];

  assign active = (sx < H_ACT) && (sy < V_ACT);
  // !ack_i keeps the PPU's still-high strobe from being taken twice.
  assign push   = stb_i && !ack_i && !full;
  // A byte written this cycle is not visible yet, since empty is pre-edge state.
  assign pop    = active && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sx <= '0;
      sy <= '0;
    end else if (sx == H_LAST) begin
      sx <= '0;
      sy <= (sy == V_LAST) ? '0 : sy + 1'b1;
    end else begin
      sx <= sx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_cnt[FIFO_AW-1:0]] <= data_i[7:2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) wr_cnt <= wr_cnt + 1'b1;
      if (pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_i     <= 1'b0;
      sync_o    <= 1'b0;
      vga_r     <= 2'd0;
      vga_g     <= 2'd0;
      vga_b     <= 2'd0;
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      underflow <= 1'b0;
      uf_count  <= 8'd0;
    end else begin
      ack_i  <= push;
      // Registered, so it lands with the counters' return to (0,0).
      sync_o <= (sx == H_LAST) && (sy == V_LAST);
      vga_hs <= !((sx >= HS_BEG) && (sx < HS_END));
      vga_vs <= !((sy >= VS_BEG) && (sy < VS_END));
      if (pop) {vga_r, vga_g, vga_b} <= head;
      else     {vga_r, vga_g, vga_b} <= 6'd0;
      // Clear takes priority over a coincident underflow.
      if (clr_i) begin
        underflow <= 1'b0;
        uf_count  <= 8'd0;
      end else if (active && empty) begin
        underflow <= 1'b1;
        if (uf_count != 8'hFF) uf_count <= uf_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a reduced raster (58x27) so whole frames run quickly.
// A queue-based reference model predicts every output each cycle.
module tb_vga_scanout;
  localparam int HA = 40, HFP = 4, HSY = 8, HBP = 6;
  localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3;
  localparam int DEPTH = 8, AW = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] data = 8'd0;
  logic stb = 1'b0;
  logic clr = 1'b0;
  logic ack_i, sync_o, vga_hs, vga_vs, underflow;
  logic [1:0] vga_r, vga_g, vga_b;
  logic [7:0] uf_count;
  logic [AW:0] fifo_level;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int n;
  logic [7:0] q[$];
  logic e_ack, e_sync, e_hs, e_vs, e_uf;
  logic [5:0] e_rgb;
  logic [7:0] e_cnt;

  vga_scanout #(
    .FIFO_DEPTH(DEPTH), .FIFO_AW(AW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data), .stb_i(stb), .ack_i(ack_i),
    .sync_o(sync_o), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .clr_i(clr), .underflow(underflow),
    .uf_count(uf_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic int px();
    return n % HT;
  endfunction

  function automatic int py();
    return (n / HT) % VT;
  endfunction

  task automatic model_reset();
    n = 0;
    q.delete();
    e_ack = 0; e_sync = 0; e_hs = 1; e_vs = 1; e_uf = 0;
    e_rgb = 0; e_cnt = 0;
  endtask

  // One clock edge of the reference: pixel position is simply the cycle index.
  task automatic model_edge();
    int x, y;
    bit act, psh, ufe;
    logic [7:0] h;
    x = px();
    y = py();
    act = (x < HA) && (y < VA);
    psh = stb && !e_ack && (q.size() < DEPTH);
    ufe = act && (q.size() == 0);
    if (act && q.size() > 0) begin
      h = q.pop_front();
      e_rgb = h[7:2];
    end else begin
      e_rgb = 6'd0;
    end
    if (psh) q.push_back(data);
    e_ack  = psh;
    e_hs   = !(x >= HA + HFP && x < HA + HFP + HSY);
    e_vs   = !(y >= VA + VFP && y < VA + VFP + VSY);
    e_sync = (x == HT - 1) && (y == VT - 1);
    if (clr) begin
      e_uf = 0;
      e_cnt = 0;
    end else if (ufe) begin
      e_uf = 1;
      if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
    end
    n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (model x=%0d y=%0d)", tag, obs, exp, px(), py());
    end
  endtask

  task automatic chk_all();
    chk("ack", 32'(ack_i), 32'(e_ack));
    chk("sync", 32'(sync_o), 32'(e_sync));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    chk("hs", 32'(vga_hs), 32'(e_hs));
    chk("vs", 32'(vga_vs), 32'(e_vs));
    chk("underflow", 32'(underflow), 32'(e_uf));
    chk("uf_count", 32'(uf_count), 32'(e_cnt));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_all();
  endtask

  // Step until the next position to be processed is (x,y); DUT counters then equal (x,y).
  task automatic wait_pos(input int x, input int y);
    for (int i = 0; i < 2 * FT + 2; i++) begin
      if (px() == x && py() == y) break;
      step();
    end
    chk("wait_pos_reached", 32'(px() == x && py() == y), 32'd1);
  endtask

  // PPU-style push: hold strobe until the accept pulse comes back.
  task automatic push_byte(input logic [7:0] b);
    bit seen;
    seen = 0;
    data = b;
    stb = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (ack_i === 1'b1) seen = 1;
    end
    stb = 0;
    chk("push_ack_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int acks, b2b, hsl, vsl, first_sync;
    logic prev;

    // Reset values
    model_reset();
    repeat (3) @(negedge clk);
    chk_all();
    rst = 1;

    // Randomized traffic over more than a frame
    for (int i = 0; i < 2000; i++) begin
      stb  = ($urandom_range(0, 3) != 0);
      data = 8'($urandom);
      clr  = ($urandom_range(0, 99) == 0);
      step();
    end
    clr = 0;

    // Starvation: 10 underflowed pixels, with clear winning on both sides
    stb = 0;
    wait_pos(0, 0);
    repeat (20) step();
    clr = 1; step();
    chk("clr_wins_uf", 32'(underflow), 32'd0);
    chk("clr_wins_cnt", 32'(uf_count), 32'd0);
    clr = 0;
    repeat (10) step();
    chk("starve_uf", 32'(underflow), 32'd1);
    chk("starve_cnt", 32'(uf_count), 32'd10);
    chk("starve_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    clr = 1; step(); clr = 0;
    chk("clr_uf", 32'(underflow), 32'd0);
    chk("clr_cnt", 32'(uf_count), 32'd0);

    // Fill in vertical blanking: ack every 2nd cycle until full
    wait_pos(0, VA);
    stb = 1; data = 8'hFC;
    acks = 0; b2b = 0; prev = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (ack_i === 1'b1) begin
        acks++;
        if (prev) b2b++;
      end
      prev = ack_i;
    end
    stb = 0;
    chk("fill_acks", 32'(acks), 32'd8);
    chk("fill_b2b", 32'(b2b), 32'd0);
    chk("fill_level", 32'(fifo_level), 32'd8);

    // Primed FIFO with R, G, B bytes shows up on pixels 0..2
    wait_pos(0, 1);
    wait_pos(0, VA);
    push_byte(8'hC0);
    push_byte(8'h30);
    push_byte(8'h0C);
    wait_pos(0, 0);
    step(); chk("px0_rgb", 32'({vga_r, vga_g, vga_b}), 32'h30);
    step(); chk("px1_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0C);
    step(); chk("px2_rgb", 32'({vga_r, vga_g, vga_b}), 32'h03);
    step(); chk("px3_under", 32'(underflow), 32'd1);

    // Saturation
    clr = 1; step(); clr = 0;
    repeat (700) step();
    chk("sat_cnt", 32'(uf_count), 32'd255);
    chk("sat_uf", 32'(underflow), 32'd1);

    // More random traffic
    for (int i = 0; i < 1000; i++) begin
      stb  = ($urandom_range(0, 1) != 0);
      data = 8'($urandom);
      clr  = ($urandom_range(0, 199) == 0);
      step();
    end
    clr = 0; stb = 0;

    // Mid-line reset with five bytes queued
    wait_pos(0, 0);
    wait_pos(0, VA);
    stb = 1; data = 8'hA8;
    for (int i = 0; i < 40 && q.size() < 5; i++) step();
    stb = 0;
    wait_pos(30, VA);
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    rst = 0;
    model_reset();
    #1;
    chk_all();
    repeat (3) @(negedge clk);
    chk_all();
    rst = 1;

    // One full frame from release: sync timing and sync-pulse widths
    hsl = 0; vsl = 0; first_sync = -1;
    for (int i = 1; i <= FT; i++) begin
      step();
      if (vga_hs === 1'b0) hsl++;
      if (vga_vs === 1'b0) vsl++;
      if (sync_o === 1'b1 && first_sync < 0) first_sync = i;
    end
    chk("frame_len", 32'(first_sync), 32'(FT));
    chk("hs_low_cycles", 32'(hsl), 32'(HSY * VT));
    chk("vs_low_cycles", 32'(vsl), 32'(VSY * HT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
